// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
// Turns the ID-stage hazard, the EXE-stage taken branch and the MEM-stage
// memory handshake into per-stage freeze/flush/bubble controls, with fixed
// priority memory wait > branch flush > hazard stall. Watchdogs lock the
// pipeline in ERR when a memory wait or hazard stall never ends, and
// saturating counters track stall, memory-wait and flush cycles.
module pipeline_stall_controller #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int HAZ_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detected_signal,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_counters,
   output logic             freeze_if,
   output logic             flush_if_id,
   output logic             bubble_id_exe,
   output logic             freeze_pipe,
   output logic             wb_bubble,
   output logic [1:0]       state,
   output logic             watchdog_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] mem_wait_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HAZ      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   localparam int HAZ_W  = $clog2(HAZ_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [HAZ_W-1:0]  HAZ_LAST  = HAZ_W'(HAZ_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              watchdog_err_q, watchdog_err_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [HAZ_W-1:0]  haz_cnt_q, haz_cnt_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  mem_wait_q, mem_wait_d;
   logic [CNT_W-1:0]  flush_q, flush_d;

   logic mem_stall;
   logic err;
   logic haz_stall;
   logic mem_trip;
   logic haz_trip;

   // Stage controls: a pending memory access or the error lock holds the
   // whole pipeline; a taken branch overrides a hazard because the ID
   // instruction is being flushed anyway, so the PC must keep moving.
   always_comb begin
      mem_stall     = mem_req & ~mem_ready;
      err           = (state_q == ERR);
      freeze_pipe   = mem_stall | err;
      wb_bubble     = mem_stall | err;
      freeze_if     = mem_stall | err | (hazard_detected_signal & ~branch_taken);
      flush_if_id   = branch_taken & ~mem_stall & ~err;
      bubble_id_exe = ~mem_stall & ~err & (branch_taken | hazard_detected_signal);
      haz_stall     = freeze_if & ~freeze_pipe;
      mem_trip      = mem_stall && (wait_cnt_q == WAIT_LAST);
      haz_trip      = haz_stall && (haz_cnt_q == HAZ_LAST);
   end

   // Next state, watchdog run lengths and saturating performance counters.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d        = state_q;
      wait_cnt_d     = '0;
      haz_cnt_d      = '0;
      stall_d        = stall_q;
      mem_wait_d     = mem_wait_q;
      flush_d        = flush_q;

      if (!err) begin
         if (mem_trip || haz_trip)       state_d = ERR;
         else if (mem_stall)             state_d = MEM_WAIT;
         else if (branch_taken)          state_d = RUN;
         else if (hazard_detected_signal) state_d = HAZ;
         else                            state_d = RUN;
      end
      watchdog_err_d = (state_d == ERR);

      // Run lengths hold at their last value; reaching it already trips ERR.
      if (mem_stall) begin
         wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      end
      if (haz_stall) begin
         haz_cnt_d = (haz_cnt_q == HAZ_LAST) ? haz_cnt_q : haz_cnt_q + HAZ_W'(1);
      end

      if (clr_counters) begin
         stall_d    = '0;
         mem_wait_d = '0;
         flush_d    = '0;
      end else begin
         if (haz_stall && (stall_q != '1))            stall_d    = stall_q + CNT_W'(1);
         if (mem_stall && !err && (mem_wait_q != '1)) mem_wait_d = mem_wait_q + CNT_W'(1);
         if (flush_if_id && (flush_q != '1))          flush_d    = flush_q + CNT_W'(1);
      end
   end

   // State register: FSM, watchdog run lengths and counters, async reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= RUN;
         watchdog_err_q <= 1'b0;
         wait_cnt_q     <= '0;
         haz_cnt_q      <= '0;
         stall_q        <= '0;
         mem_wait_q     <= '0;
         flush_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q        <= state_d;
         watchdog_err_q <= watchdog_err_d;
         wait_cnt_q     <= wait_cnt_d;
         haz_cnt_q      <= haz_cnt_d;
         stall_q        <= stall_d;
         mem_wait_q     <= mem_wait_d;
         flush_q        <= flush_d;
      end
   end

   assign state           = state_q;
   assign watchdog_err    = watchdog_err_q;
   assign stall_cycles    = stall_q;
   assign mem_wait_cycles = mem_wait_q;
   assign flush_count     = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// behavioural model of the control rules.
module tb_pipeline_stall_controller;

   localparam int CW   = 4;
   localparam int MT   = 8;
   localparam int HT   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          haz, br, req, rdy, clr;
   logic          freeze_if, flush_if_id, bubble_id_exe, freeze_pipe, wb_bubble;
   logic [1:0]    state;
   logic          watchdog_err;
   logic [CW-1:0] stall_cycles, mem_wait_cycles, flush_count;

   pipeline_stall_controller #(
      .CNT_W      (CW),
      .MEM_TIMEOUT(MT),
      .HAZ_TIMEOUT(HT)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .hazard_detected_signal(haz),
      .branch_taken          (br),
      .mem_req               (req),
      .mem_ready             (rdy),
      .clr_counters          (clr),
      .freeze_if             (freeze_if),
      .flush_if_id           (flush_if_id),
      .bubble_id_exe         (bubble_id_exe),
      .freeze_pipe           (freeze_pipe),
      .wb_bubble             (wb_bubble),
      .state                 (state),
      .watchdog_err          (watchdog_err),
      .stall_cycles          (stall_cycles),
      .mem_wait_cycles       (mem_wait_cycles),
      .flush_count           (flush_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // Behavioural model: state as the spec's number, run lengths of stall
   // streaks, and counters as plain saturating integers.
   int m_state, m_mem_run, m_haz_run, m_stall, m_memw, m_flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_mem_run = 0; m_haz_run = 0;
      m_stall = 0; m_memw = 0; m_flush = 0;
   endfunction

   function automatic void model_step();
      bit ms, er, hz, fl;
      ms = req && !rdy;
      er = (m_state == 3);
      hz = !ms && !er && haz && !br;
      fl = br && !ms && !er;
      m_mem_run = ms ? m_mem_run + 1 : 0;
      m_haz_run = hz ? m_haz_run + 1 : 0;
      if (clr) begin
         m_stall = 0; m_memw = 0; m_flush = 0;
      end else begin
         if (hz)        m_stall = sat_inc(m_stall);
         if (ms && !er) m_memw  = sat_inc(m_memw);
         if (fl)        m_flush = sat_inc(m_flush);
      end
      if (!er) begin
         if ((ms && m_mem_run >= MT) || (hz && m_haz_run >= HT)) m_state = 3;
         else if (ms)  m_state = 2;
         else if (br)  m_state = 0;
         else if (haz) m_state = 1;
         else          m_state = 0;
      end
   endfunction

   // Every cycle at the falling edge, compare all outputs with the model.
   always @(negedge clk) begin
      bit ms, er;
      if (cmp_en) begin
         ms = req && !rdy;
         er = (m_state == 3);
         check("freeze_if",       freeze_if,       ms || er || (haz && !br));
         check("flush_if_id",     flush_if_id,     br && !ms && !er);
         check("bubble_id_exe",   bubble_id_exe,   !ms && !er && (br || haz));
         check("freeze_pipe",     freeze_pipe,     ms || er);
         check("wb_bubble",       wb_bubble,       ms || er);
         check("state",           state,           m_state);
         check("watchdog_err",    watchdog_err,    m_state == 3);
         check("stall_cycles",    stall_cycles,    m_stall);
         check("mem_wait_cycles", mem_wait_cycles, m_memw);
         check("flush_count",     flush_count,     m_flush);
      end
   end

   // Drive inputs just after a rising edge and wait to mid-cycle.
   task automatic apply(input logic h, input logic b, input logic q, input logic d, input logic c);
      haz = h; br = b; req = q; rdy = d; clr = c;
      #4;
   endtask

   // Advance through one rising edge, updating the model alongside the DUT.
   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      apply(0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      haz = 0; br = 0; req = 0; rdy = 0; clr = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cmp_en = 1'b1;

      // Asynchronous reset in the middle of a memory wait.
      apply(0, 0, 1, 0, 0); tick();
      apply(0, 0, 1, 0, 0); tick();
      apply(0, 0, 1, 0, 0);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_state",        state,           0);
      check("rst_watchdog",     watchdog_err,    0);
      check("rst_stall",        stall_cycles,    0);
      check("rst_memw",         mem_wait_cycles, 0);
      check("rst_flush",        flush_count,     0);
      check("rst_freeze_pipe",  freeze_pipe,     1);
      tick();
      rst = 1'b1;
      apply(0, 0, 0, 0, 0);
      check("idle_freeze_if",   freeze_if,       0);
      check("idle_flush",       flush_if_id,     0);
      check("idle_bubble",      bubble_id_exe,   0);
      check("idle_freeze_pipe", freeze_pipe,     0);
      tick();

      // Single-cycle hazard.
      do_reset();
      apply(1, 0, 0, 0, 0);
      check("haz_freeze_if",    freeze_if,     1);
      check("haz_bubble",       bubble_id_exe, 1);
      check("haz_freeze_pipe",  freeze_pipe,   0);
      tick();
      check("haz_state",        state,         1);
      check("haz_stall_cnt",    stall_cycles,  1);

      // Branch overrides hazard.
      do_reset();
      apply(1, 1, 0, 0, 0);
      check("br_flush",         flush_if_id,   1);
      check("br_bubble",        bubble_id_exe, 1);
      check("br_freeze_if",     freeze_if,     0);
      tick();
      check("br_flush_cnt",     flush_count,   1);
      check("br_stall_cnt",     stall_cycles,  0);

      // Memory wait holds a pending branch until mem_ready.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 1, 0, 0);
         check("mw_freeze_pipe", freeze_pipe, 1);
         check("mw_freeze_if",   freeze_if,   1);
         check("mw_wb_bubble",   wb_bubble,   1);
         check("mw_flush",       flush_if_id, 0);
         tick();
      end
      check("mw_cnt",           mem_wait_cycles, 3);
      apply(0, 1, 1, 1, 0);
      check("mw_release_flush", flush_if_id, 1);
      tick();

      // Memory watchdog: 8 consecutive stall cycles lock into ERR.
      do_reset();
      for (int i = 0; i < MT; i++) begin
         apply(0, 0, 1, 0, 0);
         tick();
         if (i < MT - 1) check("wd_pre_state", state, 2);
      end
      check("wd_state",         state,        3);
      check("wd_err",           watchdog_err, 1);
      apply(0, 1, 1, 1, 0);
      check("wd_freeze_if",     freeze_if,     1);
      check("wd_freeze_pipe",   freeze_pipe,   1);
      check("wd_wb_bubble",     wb_bubble,     1);
      check("wd_flush",         flush_if_id,   0);
      check("wd_bubble",        bubble_id_exe, 0);
      tick();
      check("wd_sticky",        state,        3);

      // Stall counter saturation and clear.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(1, 0, 0, 0, 0); tick();
         apply(0, 0, 0, 0, 0); tick();
      end
      check("sat_stall",        stall_cycles, 15);
      check("sat_no_err",       watchdog_err, 0);
      apply(0, 0, 0, 0, 1); tick();
      check("clr_stall",        stall_cycles, 0);

      // Randomized stimulus against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 2 || (m_state == 3 && $urandom_range(9) == 0)) do_reset();
         apply($urandom_range(99) < 35, $urandom_range(99) < 20,
               $urandom_range(99) < 50, $urandom_range(99) < 55,
               $urandom_range(99) < 4);
         tick();
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
